// File: rtl/csa_wide_add_seq.sv
// Wide adder sequencer: NUM_SEG slices of SEG_WIDTH bits, LSB slice first,
// through one shared carry-select segment adder with a registered slice carry.

module csa_seg #(
  parameter int W = 37
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         cout
);
  localparam int L = W / 2;
  localparam int H = W - L;

  logic [L:0] lo;
  logic [H:0] hi0;
  logic [H:0] hi1;

  assign lo  = {1'b0, a[L-1:0]} + {1'b0, b[L-1:0]};
  assign hi0 = {1'b0, a[W-1:L]} + {1'b0, b[W-1:L]};
  assign hi1 = hi0 + 1'b1;

  // Upper half is precomputed for both carries and picked by the lower carry.
  assign {cout, sum} = lo[L] ? {hi1, lo[L-1:0]}
                             : {hi0, lo[L-1:0]};
endmodule

module csa_wide_add_seq #(
  parameter int SEG_WIDTH = 37,
  parameter int NUM_SEG   = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic [SEG_WIDTH*NUM_SEG-1:0] i_add_term1,
  input  logic [SEG_WIDTH*NUM_SEG-1:0] i_add_term2,
  input  logic                         i_cin,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [SEG_WIDTH*NUM_SEG-1:0] o_sum,
  output logic                         o_cout,
  output logic                         o_busy
);
  localparam int TW = SEG_WIDTH * NUM_SEG;
  localparam int IW = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [TW-1:0]        a_q;
  logic [TW-1:0]        b_q;
  logic [TW-1:0]        sum_q;
  logic                 carry_q;
  logic                 cout_q;
  logic [IW-1:0]        idx_q;
  logic [SEG_WIDTH-1:0] a_s;
  logic [SEG_WIDTH-1:0] b_s;
  logic [SEG_WIDTH-1:0] s_a;
  logic [SEG_WIDTH-1:0] seg;
  logic                 c_a;
  logic                 c_next;
  logic                 accept;
  logic                 last;

  assign a_s = a_q[int'(idx_q)*SEG_WIDTH +: SEG_WIDTH];
  assign b_s = b_q[int'(idx_q)*SEG_WIDTH +: SEG_WIDTH];

  csa_seg #(.W(SEG_WIDTH)) u_seg (
    .a    (a_s),
    .b    (b_s),
    .sum  (s_a),
    .cout (c_a)
  );

  // Increment overflow only when s_a is all ones, which rules out c_a.
  assign seg    = s_a + SEG_WIDTH'(carry_q);
  assign c_next = c_a | (carry_q & (&s_a));

  assign accept = i_valid && (state == IDLE);
  assign last   = (idx_q == IW'(NUM_SEG - 1));

  assign o_ready = (state == IDLE);
  assign o_valid = (state == DONE);
  assign o_busy  = (state == RUN);
  assign o_sum   = sum_q;
  assign o_cout  = cout_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept)  state_nx = RUN;
      RUN:     if (last)    state_nx = DONE;
      DONE:    if (i_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else if (accept) begin
      a_q     <= i_add_term1;
      b_q     <= i_add_term2;
      carry_q <= i_cin;
      idx_q   <= '0;
    end else if (state == RUN) begin
      sum_q[int'(idx_q)*SEG_WIDTH +: SEG_WIDTH] <= seg;
      carry_q <= c_next;
      idx_q   <= last ? '0 : idx_q + 1'b1;
      if (last) cout_q <= c_next;
    end
  end
endmodule

// File: tb/tb_csa_wide_add_seq.sv
// Scoreboard bench for csa_wide_add_seq: random and corner operands
// checked against plain wide-integer addition, in order, with latency.

module tb_csa_wide_add_seq;
  localparam int SW = 37;
  localparam int NS = 4;
  localparam int TW = SW * NS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic [TW-1:0] a_in = '0;
  logic [TW-1:0] b_in = '0;
  logic          cin = 1'b0;
  logic          o_valid;
  logic          i_ready = 1'b0;
  logic [TW-1:0] o_sum;
  logic          o_cout;
  logic          o_busy;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            rdy_mode = 1;
  logic          prev_valid = 1'b0;
  logic [TW:0]   sb_q[$];
  int            lat_q[$];

  csa_wide_add_seq #(.SEG_WIDTH(SW), .NUM_SEG(NS)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_add_term1 (a_in),
    .i_add_term2 (b_in),
    .i_cin       (cin),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_sum       (o_sum),
    .o_cout      (o_cout),
    .o_busy      (o_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       i_ready = 1'b0;
      1:       i_ready = 1'b1;
      default: i_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic chk(input string name, input logic [TW:0] act,
                     input logic [TW:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [TW-1:0] rnd();
    logic [159:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return r[TW-1:0];
  endfunction

  function automatic logic [TW:0] model(input logic [TW-1:0] a,
                                        input logic [TW-1:0] b,
                                        input logic c);
    return {1'b0, a} + {1'b0, b} + {{TW{1'b0}}, c};
  endfunction

  // Monitor: latency on each rising o_valid, data on each transfer.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_valid && !prev_valid) begin
        if (lat_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL latency: o_valid rose with no op pending");
        end else begin
          chk("latency", (TW+1)'(cyc - lat_q[0]), (TW+1)'(NS + 1));
        end
      end
      if (o_valid && i_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL result: got %h expected nothing", {o_cout, o_sum});
        end else begin
          chk("result", {o_cout, o_sum}, sb_q.pop_front());
          void'(lat_q.pop_front());
        end
      end
    end
    prev_valid = o_valid && rst_n;
  end

  task automatic issue(input logic [TW-1:0] a, input logic [TW-1:0] b,
                       input logic c);
    int n = 0;
    @(negedge clk);
    while (!o_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!o_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: o_ready got 0 expected 1");
    end
    a_in    = a;
    b_in    = b;
    cin     = c;
    i_valid = 1'b1;
    sb_q.push_back(model(a, b, c));
    lat_q.push_back(cyc);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    a_in    = rnd();
    b_in    = rnd();
    cin     = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", (TW+1)'(sb_q.size()), '0);
  endtask

  initial begin
    logic [TW-1:0] ones;
    logic [TW-1:0] x;
    logic [TW:0]   e;
    int            n;
    ones = '1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", (TW+1)'(o_valid), '0);
    chk("rst_sum", {1'b0, o_sum}, '0);
    chk("rst_cout", (TW+1)'(o_cout), '0);
    chk("rst_busy", (TW+1)'(o_busy), '0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", (TW+1)'(o_ready), (TW+1)'(1));

    rdy_mode = 1;
    issue(ones, '0, 1'b1);
    x = '0;
    x[SW-1:0] = '1;
    issue(x, '0, 1'b1);
    x = '0;
    x[TW-1] = 1'b1;
    issue(x, x, 1'b0);
    issue(x - 1'b1, x - 1'b1, 1'b0);
    drain();

    // Hold in DONE with the consumer stalled; new requests must be ignored.
    rdy_mode = 0;
    issue(ones, 148'd5, 1'b0);
    e = model(ones, 148'd5, 1'b0);
    n = 0;
    while (!o_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (10) begin
      @(negedge clk);
      i_valid = 1'b1;
      a_in    = rnd();
      chk("hold_result", {o_cout, o_sum}, e);
      chk("hold_ready", (TW+1)'(o_ready), '0);
      chk("hold_valid", (TW+1)'(o_valid), (TW+1)'(1));
    end
    i_valid  = 1'b0;
    rdy_mode = 1;
    drain();

    // Reset during the second RUN cycle abandons the op.
    issue(rnd(), rnd(), 1'b1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_valid", (TW+1)'(o_valid), '0);
    chk("abort_sum", {1'b0, o_sum}, '0);
    chk("abort_ready", (TW+1)'(o_ready), (TW+1)'(1));
    sb_q.delete();
    lat_q.delete();
    rst_n = 1'b1;
    issue(ones, 148'd1, 1'b0);
    drain();

    rdy_mode = 2;
    for (int i = 0; i < 1000; i++) begin
      logic [TW-1:0] a;
      logic [TW-1:0] b;
      a = rnd();
      case ($urandom_range(0, 3))
        0:       b = ~a;
        1:       b = '0;
        default: b = rnd();
      endcase
      if ($urandom_range(0, 7) == 0) a = ones;
      issue(a, b, 1'($urandom_range(0, 1)));
    end
    rdy_mode = 1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
